// File: rtl/demux4_deser.sv
// Serial-to-parallel receiver that routes each completed WIDTH-bit word to one of
// four per-channel holding registers with valid/ready handshake and sticky overflow.

module demux4_deser_chan #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             deliver_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             ready_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             ovf_o
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             xfer;

  assign xfer = valid_q & ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_clr_i ? 1'b0 : ovf_q;
    if (deliver_i) begin
      // A slot freed by a same-cycle transfer can take the new word.
      if (!valid_q || xfer) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;
endmodule

module demux4_deser #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               din,
  input  logic               din_valid,
  input  logic [1:0]         sel,
  input  logic               sel_load,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [3:0]         overflow,
  input  logic               ovf_clr,
  output logic               busy,
  output logic [3:0]         led
);
  localparam int NUM_LANES = 4;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       active_ch_q, active_ch_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             busy_q;
  logic [3:0]       led_q;
  logic             word_done;
  logic [WIDTH-1:0] word;
  logic [NUM_LANES-1:0]            deliver;
  logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;

  assign word      = {sr_q[WIDTH-2:0], din};
  assign word_done = din_valid && (bit_cnt_q == LAST);

  always_comb begin
    active_ch_d = active_ch_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    // Channel changes only between words so a word never straddles two channels.
    if (sel_load && bit_cnt_q == '0) active_ch_d = sel;
    if (din_valid) begin
      sr_d      = word;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + CW'(1);
    end
  end

  // Completion never coincides with a channel switch, so active_ch_q is the word's owner.
  assign deliver = word_done ? (NUM_LANES'(1) << active_ch_q) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_ch_q <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      busy_q      <= 1'b0;
      led_q       <= 4'b0001;
    end else begin
      active_ch_q <= active_ch_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      busy_q      <= (bit_cnt_d != '0);
      led_q       <= NUM_LANES'(1) << active_ch_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    demux4_deser_chan #(.WIDTH(WIDTH)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .deliver_i (deliver[g]),
      .word_i    (word),
      .ready_i   (out_ready[g]),
      .ovf_clr_i (ovf_clr),
      .data_o    (lane_data[g]),
      .valid_o   (out_valid[g]),
      .ovf_o     (overflow[g])
    );
  end

  assign out_data = lane_data;
  assign busy     = busy_q;
  assign led      = led_q;
endmodule
